// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, register indices and memtoReg encodings
// used by the decoder, the MEM/WB register and the writeback stage.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      MEMTOREG_ALU  = 2'b00,
      MEMTOREG_MEM  = 2'b01,
      MEMTOREG_LINK = 2'b10,
      MEMTOREG_RSVD = 2'b11
   } memtoreg_e;

endpackage

// File: rtl/wb_mux.sv
// Writeback data select: ALU result, load data or the PC+4 return link.
// The reserved encoding yields zero so a bad decode can never leak stale data.
module wb_mux
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W
) (
   input  logic [1:0]        memtoreg_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] read_data_i,
   input  logic [DATA_W-1:0] pc_i,
   output logic [DATA_W-1:0] wb_data_o
);

   logic [DATA_W-1:0] link_addr;

   // Link value wraps modulo 2^DATA_W, so the top word of memory links to 0.
   assign link_addr = pc_i + DATA_W'(4);

   always_comb begin
      wb_data_o = '0;
      case (memtoreg_e'(memtoreg_i))
         MEMTOREG_ALU:  wb_data_o = alu_result_i;
         MEMTOREG_MEM:  wb_data_o = read_data_i;
         MEMTOREG_LINK: wb_data_o = link_addr;
         default:       wb_data_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and general register file: selects writeback data, commits it,
// serves rs/rt reads and counts committed writes. Macro WB_READ_BYPASS_EN enables
// same-cycle write-before-read on the read ports.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int NREG   = cpu_pkg::NREG,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        memtoReg,
   input  logic              regWrite,
   input  logic              hold,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] readData,
   input  logic [DATA_W-1:0] PC,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_commit,
   output logic [CNT_W-1:0]  wr_count
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [CNT_W-1:0]  wr_count_q;
   logic [CNT_W-1:0]  wr_count_d;
   logic [DATA_W-1:0] rs_stored;
   logic [DATA_W-1:0] rt_stored;

   wb_mux #(
      .DATA_W (DATA_W)
   ) u_wb_mux (
      .memtoreg_i   (memtoReg),
      .alu_result_i (ALUResult),
      .read_data_i  (readData),
      .pc_i         (PC),
      .wb_data_o    (wb_data)
   );

   // Register 0 is hardwired zero, so writes to it are dropped and not counted.
   assign wb_commit = regWrite & ~hold & (writeReg != '0);

   always_comb begin
      wr_count_d = wr_count_q;
      if (wb_commit) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else begin
         if (wb_commit) begin
            regs_q[writeReg] <= wb_data;
         end
         wr_count_q <= wr_count_d;
      end
   end

   assign wr_count  = wr_count_q;
   assign rs_stored = (rs_addr == '0) ? '0 : regs_q[rs_addr];
   assign rt_stored = (rt_addr == '0) ? '0 : regs_q[rt_addr];

`ifdef WB_READ_BYPASS_EN
   // Bypass is gated by rst so reads stay zero for the whole reset window.
   always_comb begin
      rs_data = rs_stored;
      rt_data = rt_stored;
      if (rst && wb_commit && (rs_addr == writeReg)) begin
         rs_data = wb_data;
      end
      if (rst && wb_commit && (rt_addr == writeReg)) begin
         rt_data = wb_data;
      end
   end
`else
   // Stored contents only; the hazard unit forwards from wb_data for the gap cycle.
   assign rs_data = rs_stored;
   assign rt_data = rt_stored;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps then randomized writeback traffic
// against an array model; a second instance with a 4-bit counter exercises wrap.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [1:0]  memtoReg;
   logic        regWrite;
   logic        hold;
   logic [31:0] ALUResult;
   logic [31:0] readData;
   logic [31:0] PC;
   logic [4:0]  writeReg;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data;
   logic        wb_commit;
   logic [31:0] wr_count;
   logic [31:0] n_rs_data;
   logic [31:0] n_rt_data;
   logic [31:0] n_wb_data;
   logic        n_wb_commit;
   logic [3:0]  n_wr_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [32];
   logic [31:0] model_cnt;

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .memtoReg  (memtoReg),
      .regWrite  (regWrite),
      .hold      (hold),
      .ALUResult (ALUResult),
      .readData  (readData),
      .PC        (PC),
      .writeReg  (writeReg),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .wb_data   (wb_data),
      .wb_commit (wb_commit),
      .wr_count  (wr_count)
   );

   wb_regfile #(.CNT_W(4)) dut_n (
      .clk       (clk),
      .rst       (rst),
      .memtoReg  (memtoReg),
      .regWrite  (regWrite),
      .hold      (hold),
      .ALUResult (ALUResult),
      .readData  (readData),
      .PC        (PC),
      .writeReg  (writeReg),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (n_rs_data),
      .rt_data   (n_rt_data),
      .wb_data   (n_wb_data),
      .wb_commit (n_wb_commit),
      .wr_count  (n_wr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_wb(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] rd, input logic [31:0] pc);
      logic [32:0] link;
      link = {1'b0, pc} + 33'd4;
      case (sel)
         2'd0:    return alu;
         2'd1:    return rd;
         2'd2:    return link[31:0];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a, input logic c,
                                            input logic [4:0] w, input logic [31:0] v);
      if (a == 5'd0) return 32'h0;
`ifdef WB_READ_BYPASS_EN
      if (c && a == w) return v;
`else
      if (c && a == w && v === 32'hx) return 32'h0;
`endif
      return model[a];
   endfunction

   task automatic drive(input logic [1:0] sel, input logic we, input logic hd,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc,
                        input logic [4:0] wr, input logic [4:0] ra, input logic [4:0] rb);
      memtoReg  = sel;
      regWrite  = we;
      hold      = hd;
      ALUResult = alu;
      readData  = rd;
      PC        = pc;
      writeReg  = wr;
      rs_addr   = ra;
      rt_addr   = rb;
   endtask

   // Checks combinational outputs before the edge, then state and reads after it.
   task automatic cycle_check(input string tag);
      logic        c;
      logic [31:0] v;
      #1;
      c = regWrite && !hold && (writeReg != 5'd0);
      v = exp_wb(memtoReg, ALUResult, readData, PC);
      chk({tag, "_wb"}, wb_data, v);
      chk({tag, "_commit"}, {31'b0, wb_commit}, {31'b0, c});
      chk({tag, "_rs_pre"}, rs_data, exp_read(rs_addr, c, writeReg, v));
      chk({tag, "_rt_pre"}, rt_data, exp_read(rt_addr, c, writeReg, v));
      @(posedge clk);
      if (c) begin
         model[writeReg] = v;
         model_cnt = model_cnt + 32'd1;
      end
      #1;
      chk({tag, "_cnt"}, wr_count, model_cnt);
      chk({tag, "_cnt4"}, {28'b0, n_wr_count}, {28'b0, model_cnt[3:0]});
      chk({tag, "_rs_post"}, rs_data, exp_read(rs_addr, c, writeReg, v));
      chk({tag, "_rt_post"}, n_rt_data, exp_read(rt_addr, c, writeReg, v));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_cnt = 32'h0;
      rst = 1'b0;
      drive(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         #1;
         chk($sformatf("rst_rs%0d", i), rs_data, 32'h0);
         chk($sformatf("rst_rt%0d", 31 - i), rt_data, 32'h0);
      end
      chk("rst_cnt", wr_count, 32'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // ALU write to r8; first commit after reset gives count 1
      drive(2'b00, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
      cycle_check("alu");
      chk("alu_r8", rs_data, 32'h0000_1234);
      chk("alu_first_cnt", wr_count, 32'd1);

      drive(2'b01, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd0, 5'd9);
      cycle_check("load");
      chk("load_r9", rt_data, 32'hDEAD_BEEF);

      drive(2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0040_0010, 5'd31, 5'd9, 5'd31);
      cycle_check("link");
      chk("link_r31", rt_data, 32'h0040_0014);

      drive(2'b00, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      cycle_check("r0");
      chk("r0_commit", {31'b0, wb_commit}, 32'd0);
      chk("r0_read", rs_data, 32'h0);
      chk("r0_cnt", wr_count, 32'd3);

      drive(2'b00, 1'b1, 1'b1, 32'h5555_0005, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
      cycle_check("hold");
      chk("hold_r5", rs_data, 32'h0);
      drive(2'b00, 1'b1, 1'b0, 32'h5555_0005, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
      cycle_check("unhold");
      chk("unhold_r5", rs_data, 32'h5555_0005);

      drive(2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd12, 5'd12, 5'd0);
      cycle_check("linkwrap");
      chk("linkwrap_r12", rs_data, 32'h0);
      drive(2'b11, 1'b1, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 5'd13, 5'd13, 5'd8);
      cycle_check("rsvd");

      drive(2'b00, 1'b1, 1'b0, 32'h0000_00AA, 32'h0, 32'h0, 5'd10, 5'd10, 5'd10);
      #1;
`ifdef WB_READ_BYPASS_EN
      chk("bypass_pre", rs_data, 32'h0000_00AA);
`else
      chk("bypass_pre", rs_data, 32'h0);
`endif
      chk("bypass_same", rt_data, rs_data);
      cycle_check("bypass");
      chk("bypass_post", rs_data, 32'h0000_00AA);

      for (int n = 0; n < 300; n++) begin
         logic [4:0] wr;
         wr = 5'($urandom_range(0, 31));
         drive(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
               $urandom, $urandom, $urandom, wr,
               ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));
         cycle_check($sformatf("rnd%0d", n));
      end

      // Reset asserted mid-cycle with a commit pending
      drive(2'b00, 1'b1, 1'b0, 32'hCAFE_0003, 32'h0, 32'h0, 5'd3, 5'd8, 5'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_rs", rs_data, 32'h0);
      chk("arst_rt", rt_data, 32'h0);
      chk("arst_cnt", wr_count, 32'h0);
      @(posedge clk);
      #1;
      chk("arst_edge_rt", rt_data, 32'h0);
      chk("arst_edge_cnt", wr_count, 32'h0);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_cnt = 32'h0;
      regWrite = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd8);
      cycle_check("post_arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
